// File: rtl/lsu_store_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_store_queue_if
//  Description : AGU -> LSU issue bus. The AGU drives the request fields and
//                the LSU answers with combinational backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
interface lsu_store_queue_if;
    logic        lsu_vld_i;
    logic [5:0]  lsu_rob_i;
    logic        lsu_cmo_i;
    logic [3:0]  lsu_op_i;
    logic [31:0] lsu_addr_i;
    logic [5:0]  lsu_dest_i;
    logic [31:0] lsu_sq_data_i;
    logic [3:0]  lsu_sq_bm_i;
    logic        lsu_busy_o;

    modport master (
        output lsu_vld_i, lsu_rob_i, lsu_cmo_i, lsu_op_i, lsu_addr_i,
               lsu_dest_i, lsu_sq_data_i, lsu_sq_bm_i,
        input  lsu_busy_o
    );

    modport slave (
        input  lsu_vld_i, lsu_rob_i, lsu_cmo_i, lsu_op_i, lsu_addr_i,
               lsu_dest_i, lsu_sq_data_i, lsu_sq_bm_i,
        output lsu_busy_o
    );
endinterface
`default_nettype wire

// File: rtl/lsu_store_queue.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_store_queue
//  Description : Store queue with commit/drain to the dcache write port and a
//                registered load/CMO pass-through guarded by address hazards.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_store_queue #(
    parameter int SQ_DEPTH = 4
) (
    input  wire logic        cpu_clock_i,
    input  wire logic        cpu_resetn_i,
    input  wire logic        flush_i,
    lsu_store_queue_if.slave agu,
    output logic             ld_vld_o,
    output logic [5:0]       ld_rob_o,
    output logic [5:0]       ld_dest_o,
    output logic [3:0]       ld_op_o,
    output logic             ld_cmo_o,
    output logic [31:0]      ld_addr_o,
    output logic [3:0]       ld_bm_o,
    input  wire logic        ld_busy_i,
    output logic             st_done_o,
    output logic [5:0]       st_done_rob_o,
    input  wire logic        sq_commit_i,
    output logic             dc_wr_vld_o,
    output logic [29:0]      dc_wr_addr_o,
    output logic [31:0]      dc_wr_data_o,
    output logic [3:0]       dc_wr_bm_o,
    input  wire logic        dc_wr_ack_i
);

    localparam int            c_PW      = $clog2(SQ_DEPTH);
    localparam logic [c_PW:0] c_DEPTH   = (c_PW+1)'(SQ_DEPTH);
    localparam logic [c_PW:0] c_PTR_ONE = (c_PW+1)'(1);

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [c_PW:0]  r_head;
    logic [c_PW:0]  r_cmt;
    logic [c_PW:0]  r_tail;
    logic [29:0]    r_addr [SQ_DEPTH];
    logic [31:0]    r_data [SQ_DEPTH];
    logic [3:0]     r_bm   [SQ_DEPTH];

    logic           r_ld_vld;
    logic [5:0]     r_ld_rob;
    logic [5:0]     r_ld_dest;
    logic [3:0]     r_ld_op;
    logic           r_ld_cmo;
    logic [31:0]    r_ld_addr;
    logic [3:0]     r_ld_bm;
    logic           r_st_done;
    logic [5:0]     r_st_rob;

    logic [c_PW:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_is_store;
    logic [SQ_DEPTH-1:0] w_match;
    logic              w_hazard;
    logic              w_ld_stall;
    logic              w_st_acc;
    logic              w_ld_acc;
    logic              w_commit;
    logic              w_drain;
    logic [c_PW:0]     w_cmt_nxt;
    logic [c_PW-1:0]   w_tail_idx;
    logic [c_PW-1:0]   w_head_idx;

    assign w_count    = r_tail - r_head;
    assign w_full     = (w_count == c_DEPTH);
    assign w_empty    = (r_head == r_tail);
    assign w_is_store = agu.lsu_op_i[3];
    assign w_tail_idx = r_tail[c_PW-1:0];
    assign w_head_idx = r_head[c_PW-1:0];

    // An entry is live when its distance from head is below the occupancy,
    // so committed-but-undrained stores still block overlapping loads.
    generate
        for (genvar gi = 0; gi < SQ_DEPTH; gi++) begin : g_entry
            logic [c_PW-1:0] w_off;
            assign w_off       = c_PW'(gi) - w_head_idx;
            assign w_match[gi] = ({1'b0, w_off} < w_count)
                               && (r_addr[gi] == agu.lsu_addr_i[31:2])
                               && (|(r_bm[gi] & agu.lsu_sq_bm_i));
        end
    endgenerate

    assign w_hazard   = agu.lsu_cmo_i ? !w_empty : (|w_match);
    assign w_ld_stall = r_ld_vld & ld_busy_i;

    assign agu.lsu_busy_o = agu.lsu_vld_i
                          & (w_is_store ? w_full : (w_hazard | w_ld_stall));

    assign w_st_acc  = agu.lsu_vld_i &  w_is_store & !w_full & !flush_i;
    assign w_ld_acc  = agu.lsu_vld_i & !w_is_store & !w_hazard & !w_ld_stall & !flush_i;
    assign w_commit  = sq_commit_i & (r_cmt != r_tail);
    assign w_drain   = dc_wr_ack_i & (r_head != r_cmt);
    assign w_cmt_nxt = w_commit ? (r_cmt + c_PTR_ONE) : r_cmt;

    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_resetn_i) begin
            r_head <= '0;
            r_cmt  <= '0;
            r_tail <= '0;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_bm[i]   <= '0;
            end
        end else begin
            if (w_drain) begin
                r_head <= r_head + c_PTR_ONE;
            end
            r_cmt <= w_cmt_nxt;
            // Flush rewinds tail onto the commit point, discarding the
            // speculative tail of the queue while committed stores drain.
            if (flush_i) begin
                r_tail <= w_cmt_nxt;
            end else if (w_st_acc) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_st_acc) begin
                r_addr[w_tail_idx] <= agu.lsu_addr_i[31:2];
                r_data[w_tail_idx] <= agu.lsu_sq_data_i;
                r_bm[w_tail_idx]   <= agu.lsu_sq_bm_i;
            end
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_resetn_i) begin
            r_st_done <= 1'b0;
            r_st_rob  <= '0;
        end else begin
            r_st_done <= w_st_acc;
            if (w_st_acc) begin
                r_st_rob <= agu.lsu_rob_i;
            end
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_resetn_i) begin
            r_ld_vld  <= 1'b0;
            r_ld_rob  <= '0;
            r_ld_dest <= '0;
            r_ld_op   <= '0;
            r_ld_cmo  <= 1'b0;
            r_ld_addr <= '0;
            r_ld_bm   <= '0;
        end else if (flush_i) begin
            r_ld_vld <= 1'b0;
        end else if (w_ld_acc) begin
            r_ld_vld  <= 1'b1;
            r_ld_rob  <= agu.lsu_rob_i;
            r_ld_dest <= agu.lsu_dest_i;
            r_ld_op   <= agu.lsu_op_i;
            r_ld_cmo  <= agu.lsu_cmo_i;
            r_ld_addr <= agu.lsu_addr_i;
            r_ld_bm   <= agu.lsu_sq_bm_i;
        end else if (!ld_busy_i) begin
            r_ld_vld <= 1'b0;
        end
    end

    assign ld_vld_o      = r_ld_vld;
    assign ld_rob_o      = r_ld_rob;
    assign ld_dest_o     = r_ld_dest;
    assign ld_op_o       = r_ld_op;
    assign ld_cmo_o      = r_ld_cmo;
    assign ld_addr_o     = r_ld_addr;
    assign ld_bm_o       = r_ld_bm;
    assign st_done_o     = r_st_done;
    assign st_done_rob_o = r_st_rob;

    assign dc_wr_vld_o  = (r_head != r_cmt);
    assign dc_wr_addr_o = r_addr[w_head_idx];
    assign dc_wr_data_o = r_data[w_head_idx];
    assign dc_wr_bm_o   = r_bm[w_head_idx];

`ifndef SYNTHESIS
    // A commit with no uncommitted store means the ROB and queue disagree.
    a_commit_has_entry : assert property (
        @(posedge cpu_clock_i) disable iff (!cpu_resetn_i)
        !(sq_commit_i && (r_cmt == r_tail))
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_store_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_store_queue
//  Description : Directed bench for lsu_store_queue with scoreboards for the
//                store-done, dcache-write and load-pipe outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_store_queue;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        ld_busy;
    logic        sq_commit;
    logic        dc_ack;
    logic        ld_vld;
    logic [5:0]  ld_rob;
    logic [5:0]  ld_dest;
    logic [3:0]  ld_op;
    logic        ld_cmo;
    logic [31:0] ld_addr;
    logic [3:0]  ld_bm;
    logic        st_done;
    logic [5:0]  st_done_rob;
    logic        dc_vld;
    logic [29:0] dc_addr;
    logic [31:0] dc_data;
    logic [3:0]  dc_bm;

    always #5 clk = ~clk;

    lsu_store_queue_if agu_if ();

    lsu_store_queue #(.SQ_DEPTH(4)) dut (
        .cpu_clock_i   (clk),
        .cpu_resetn_i  (rstn),
        .flush_i       (flush),
        .agu           (agu_if),
        .ld_vld_o      (ld_vld),
        .ld_rob_o      (ld_rob),
        .ld_dest_o     (ld_dest),
        .ld_op_o       (ld_op),
        .ld_cmo_o      (ld_cmo),
        .ld_addr_o     (ld_addr),
        .ld_bm_o       (ld_bm),
        .ld_busy_i     (ld_busy),
        .st_done_o     (st_done),
        .st_done_rob_o (st_done_rob),
        .sq_commit_i   (sq_commit),
        .dc_wr_vld_o   (dc_vld),
        .dc_wr_addr_o  (dc_addr),
        .dc_wr_data_o  (dc_data),
        .dc_wr_bm_o    (dc_bm),
        .dc_wr_ack_i   (dc_ack)
    );

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  bm;
    } dc_t;

    typedef struct packed {
        logic [5:0]  rob;
        logic [5:0]  dest;
        logic [3:0]  op;
        logic        cmo;
        logic [31:0] addr;
        logic [3:0]  bm;
    } ld_t;

    dc_t        q_dc [$];
    ld_t        q_ld [$];
    logic [5:0] q_st [$];
    int         n_pass = 0;
    int         n_total = 0;
    int         n_uncmt = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Output monitors pop the scoreboards whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (st_done) begin
                if (q_st.size() == 0) chk("st_done_unexpected", 96'(1), 96'(0));
                else begin
                    logic [5:0] e_rob;
                    e_rob = q_st.pop_front();
                    chk("st_done_rob", 96'(st_done_rob), 96'(e_rob));
                end
            end
            if (dc_vld && dc_ack) begin
                if (q_dc.size() == 0) chk("dc_wr_unexpected", 96'(1), 96'(0));
                else begin
                    dc_t e_dc;
                    e_dc = q_dc.pop_front();
                    chk("dc_wr", 96'({dc_addr, dc_data, dc_bm}), 96'(e_dc));
                end
            end
            if (ld_vld && !ld_busy) begin
                if (q_ld.size() == 0) chk("ld_unexpected", 96'(1), 96'(0));
                else begin
                    ld_t e_ld;
                    e_ld = q_ld.pop_front();
                    chk("ld_out", 96'({ld_rob, ld_dest, ld_op, ld_cmo, ld_addr, ld_bm}), 96'(e_ld));
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic st, input logic cmo, input logic [31:0] addr,
                           input logic [3:0] bm, input logic [31:0] data,
                           input logic [5:0] rob, input logic [5:0] dest);
        agu_if.lsu_vld_i     = 1'b1;
        agu_if.lsu_op_i      = {st, 3'd2};
        agu_if.lsu_cmo_i     = cmo;
        agu_if.lsu_addr_i    = addr;
        agu_if.lsu_sq_bm_i   = bm;
        agu_if.lsu_sq_data_i = data;
        agu_if.lsu_rob_i     = rob;
        agu_if.lsu_dest_i    = dest;
    endtask

    task automatic clr_req;
        agu_if.lsu_vld_i = 1'b0;
    endtask

    task automatic push_store(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] bm, input logic [5:0] rob);
        dc_t e;
        e.a  = addr[31:2];
        e.d  = data;
        e.bm = bm;
        q_dc.push_back(e);
        q_st.push_back(rob);
        n_uncmt++;
    endtask

    task automatic push_load(input logic [31:0] addr, input logic [3:0] bm,
                             input logic [5:0] rob, input logic [5:0] dest, input logic cmo);
        ld_t e;
        e.rob  = rob;
        e.dest = dest;
        e.op   = 4'b0010;
        e.cmo  = cmo;
        e.addr = addr;
        e.bm   = bm;
        q_ld.push_back(e);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] bm, input logic [5:0] rob);
        set_req(1'b1, 1'b0, addr, bm, data, rob, 6'd0);
        @(negedge clk);
        chk("store_busy", 96'(agu_if.lsu_busy_o), 96'(0));
        push_store(addr, data, bm, rob);
        tick;
        clr_req;
    endtask

    task automatic load(input logic [31:0] addr, input logic [3:0] bm,
                        input logic [5:0] rob, input logic [5:0] dest);
        set_req(1'b0, 1'b0, addr, bm, 32'h0, rob, dest);
        @(negedge clk);
        chk("load_busy", 96'(agu_if.lsu_busy_o), 96'(0));
        push_load(addr, bm, rob, dest, 1'b0);
        tick;
        clr_req;
    endtask

    task automatic commit;
        sq_commit = 1'b1;
        n_uncmt--;
        tick;
        sq_commit = 1'b0;
    endtask

    task automatic drain;
        dc_ack = 1'b1;
        @(negedge clk);
        chk("drain_dc_vld", 96'(dc_vld), 96'(1));
        tick;
        dc_ack = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; ld_busy = 1'b0; sq_commit = 1'b0; dc_ack = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 6'd0, 6'd0);
        clr_req;
        repeat (3) tick;
        @(negedge clk);
        chk("rst_dc_vld",  96'(dc_vld),  96'(0));
        chk("rst_ld_vld",  96'(ld_vld),  96'(0));
        chk("rst_st_done", 96'(st_done), 96'(0));
        chk("rst_busy",    96'(agu_if.lsu_busy_o), 96'(0));
        chk("rst_dc_addr", 96'(dc_addr), 96'(0));
        chk("rst_ld_addr", 96'(ld_addr), 96'(0));
        tick;
        rstn = 1'b1;
        tick;

        // Single store through commit and drain.
        store(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 6'd3);
        @(negedge clk);
        chk("t1_no_dc_before_commit", 96'(dc_vld), 96'(0));
        tick;
        commit;
        @(negedge clk);
        chk("t1_dc_vld",  96'(dc_vld),  96'(1));
        chk("t1_dc_addr", 96'(dc_addr), 96'(30'h400));
        tick;
        drain;
        @(negedge clk);
        chk("t1_empty", 96'(dc_vld), 96'(0));
        tick;

        // Fill to full, fifth store held until a drain frees a slot.
        for (int k = 0; k < 4; k++)
            store(32'h0000_3000 + 32'(4 * k), 32'h1111_0000 + 32'(k), 4'hF, 6'(10 + k));
        set_req(1'b1, 1'b0, 32'h0000_3010, 4'hF, 32'h5555_5555, 6'd14, 6'd0);
        @(negedge clk);
        chk("t2_full_busy", 96'(agu_if.lsu_busy_o), 96'(1));
        tick;
        sq_commit = 1'b1;
        n_uncmt--;
        @(negedge clk);
        chk("t2_busy_commit", 96'(agu_if.lsu_busy_o), 96'(1));
        tick;
        sq_commit = 1'b0;
        dc_ack = 1'b1;
        @(negedge clk);
        chk("t2_busy_drain_cycle", 96'(agu_if.lsu_busy_o), 96'(1));
        tick;
        dc_ack = 1'b0;
        @(negedge clk);
        chk("t2_fifth_accept", 96'(agu_if.lsu_busy_o), 96'(0));
        push_store(32'h0000_3010, 32'h5555_5555, 4'hF, 6'd14);
        tick;
        clr_req;
        repeat (4) commit;
        repeat (4) drain;

        // Byte-mask hazard: disjoint lanes pass, overlapping lanes wait for drain.
        store(32'h0000_2004, 32'h0000_ABCD, 4'b0011, 6'd20);
        load(32'h0000_2006, 4'b1100, 6'd21, 6'd7);
        set_req(1'b0, 1'b0, 32'h0000_2004, 4'b0001, 32'h0, 6'd22, 6'd5);
        @(negedge clk);
        chk("t3_hazard_busy", 96'(agu_if.lsu_busy_o), 96'(1));
        tick;
        sq_commit = 1'b1;
        n_uncmt--;
        @(negedge clk);
        chk("t3_hazard_uncommitted", 96'(agu_if.lsu_busy_o), 96'(1));
        tick;
        sq_commit = 1'b0;
        dc_ack = 1'b1;
        @(negedge clk);
        chk("t3_hazard_committed", 96'(agu_if.lsu_busy_o), 96'(1));
        tick;
        dc_ack = 1'b0;
        @(negedge clk);
        chk("t3_hazard_clear", 96'(agu_if.lsu_busy_o), 96'(0));
        push_load(32'h0000_2004, 4'b0001, 6'd22, 6'd5, 1'b0);
        tick;
        clr_req;
        tick;

        // Flush discards the uncommitted store and a same-cycle load.
        store(32'h0000_4000, 32'hAAAA_0001, 4'hF, 6'd30);
        store(32'h0000_4004, 32'hAAAA_0002, 4'hF, 6'd31);
        commit;
        flush = 1'b1;
        set_req(1'b0, 1'b0, 32'h0000_5000, 4'hF, 32'h0, 6'd33, 6'd1);
        tick;
        flush = 1'b0;
        clr_req;
        void'(q_dc.pop_back());
        n_uncmt = 0;
        @(negedge clk);
        chk("t4_load_dropped", 96'(ld_vld), 96'(0));
        chk("t4_committed_live", 96'(dc_vld), 96'(1));
        tick;
        drain;
        @(negedge clk);
        chk("t4_uncommitted_gone", 96'(dc_vld), 96'(0));
        tick;
        store(32'h0000_4008, 32'hAAAA_0003, 4'hF, 6'd32);
        commit;
        drain;

        // Load-pipe stall holds the registered request and backpressures the AGU.
        ld_busy = 1'b1;
        load(32'h0000_6000, 4'hF, 6'd40, 6'd9);
        set_req(1'b0, 1'b0, 32'h0000_6100, 4'h3, 32'h0, 6'd41, 6'd10);
        @(negedge clk);
        chk("t5_stall_busy", 96'(agu_if.lsu_busy_o), 96'(1));
        chk("t5_ld_addr",    96'(ld_addr), 96'(32'h0000_6000));
        tick;
        @(negedge clk);
        chk("t5_ld_hold_vld",  96'(ld_vld),  96'(1));
        chk("t5_ld_hold_addr", 96'(ld_addr), 96'(32'h0000_6000));
        tick;
        ld_busy = 1'b0;
        @(negedge clk);
        chk("t5_release_busy", 96'(agu_if.lsu_busy_o), 96'(0));
        push_load(32'h0000_6100, 4'h3, 6'd41, 6'd10, 1'b0);
        tick;
        clr_req;
        @(negedge clk);
        chk("t5_second_load", 96'(ld_addr), 96'(32'h0000_6100));
        tick;
        @(negedge clk);
        chk("t5_ld_clear", 96'(ld_vld), 96'(0));
        tick;

        // Three fill/drain rounds wrap the pointers; the last round gates a CMO.
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 4; k++)
                store(32'h0000_8000 + 32'(16 * b + 4 * k), $urandom, 4'(1 + k), 6'(4 * b + k));
            repeat (4) commit;
            if (b < 2) begin
                repeat (4) drain;
            end
        end
        set_req(1'b0, 1'b1, 32'h0000_9000, 4'hF, 32'h0, 6'd50, 6'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_cmo_wait", 96'(agu_if.lsu_busy_o), 96'(1));
            tick;
            drain;
        end
        @(negedge clk);
        chk("t6_cmo_accept", 96'(agu_if.lsu_busy_o), 96'(0));
        push_load(32'h0000_9000, 4'hF, 6'd50, 6'd0, 1'b1);
        tick;
        clr_req;
        tick;

        // Reset while a committed store is waiting to drain.
        store(32'h0000_A000, 32'hCAFE_F00D, 4'hF, 6'd60);
        commit;
        @(negedge clk);
        chk("t7_pre_reset_vld", 96'(dc_vld), 96'(1));
        tick;
        rstn = 1'b0;
        tick;
        rstn = 1'b1;
        q_dc.delete();
        n_uncmt = 0;
        @(negedge clk);
        chk("t7_reset_drop", 96'(dc_vld), 96'(0));
        tick;
        tick;

        chk("sb_st_empty", 96'(q_st.size()), 96'(0));
        chk("sb_dc_empty", 96'(q_dc.size()), 96'(0));
        chk("sb_ld_empty", 96'(q_ld.size()), 96'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
